// File: rtl/rc5_pkg.sv
// RC5-32/12/16 shared constants, state encoding and rotate helper.
// Imported by the key schedule and the encrypt/decrypt cores.
package rc5_pkg;

  localparam int ROUNDS = 12;
  localparam int NW     = 2 * ROUNDS + 2;
  localparam int NK     = 4;
  localparam int MIX_N  = 3 * NW;

  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // amt==0 is special-cased so no 32-bit right shift is ever formed
  function automatic logic [31:0] rotl32(
    input logic [31:0] v,
    input logic [4:0]  amt
  );
    logic [5:0] rs;
    rs = 6'd32 - {1'b0, amt};
    if (amt == 5'd0) return v;
    return (v << amt) | (v >> rs);
  endfunction

endpackage

// File: rtl/rc5_rotl32.sv
// Combinational 32-bit rotate-left by a 5-bit amount.
// Thin wrapper so the datapath can instance the rotator explicitly.
module rc5_rotl32
  import rc5_pkg::*;
(
  input  logic [31:0] val,
  input  logic [4:0]  amt,
  output logic [31:0] res
);

  assign res = rotl32(val, amt);

endmodule

// File: rtl/rc5_key_expand.sv
// RC5-32/12/16 key schedule: builds S[0..25] from a 128-bit key.
// Table is exposed through a combinational read port.
module rc5_key_expand
  import rc5_pkg::*;
(
  input  logic         clk,
  input  logic         clr,
  input  logic [127:0] key_in,
  input  logic         key_vld,
  output logic         key_rdy,
  output logic         skey_vld,
  input  logic [4:0]   skey_rd_addr,
  output logic [31:0]  skey_rd_data
);

  state_t state, state_nx;

  logic [31:0] s_q [NW];
  logic [31:0] l_q [NK];
  logic [31:0] a_q, b_q, run_q;
  logic [4:0]  idx_q;
  logic [1:0]  j_q;
  logic [6:0]  iter_q;

  logic        start;
  logic        init_last;
  logic        mix_last;
  logic [31:0] sum_a, a_new;
  logic [31:0] ab, sum_b, b_new;

  assign start     = key_vld & key_rdy;
  assign init_last = (idx_q == 5'(NW - 1));
  assign mix_last  = (iter_q == 7'(MIX_N - 1));

  // Mix datapath: one S/L update per cycle
  assign sum_a = s_q[idx_q] + a_q + b_q;
  assign ab    = a_new + b_q;
  assign sum_b = l_q[j_q] + ab;

  rc5_rotl32 u_rot_a (
    .val (sum_a),
    .amt (5'd3),
    .res (a_new)
  );

  rc5_rotl32 u_rot_b (
    .val (sum_b),
    .amt (ab[4:0]),
    .res (b_new)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE,
      ST_DONE: if (start)     state_nx = ST_INIT;
      ST_INIT: if (init_last) state_nx = ST_MIX;
      ST_MIX:  if (mix_last)  state_nx = ST_DONE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    key_rdy  = 1'b0;
    skey_vld = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): key_rdy = 1'b1;
      (state == ST_DONE): begin
        key_rdy  = 1'b1;
        skey_vld = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int n = 0; n < NW; n++) s_q[n] <= '0;
      for (int n = 0; n < NK; n++) l_q[n] <= '0;
      a_q    <= '0;
      b_q    <= '0;
      run_q  <= '0;
      idx_q  <= '0;
      j_q    <= '0;
      iter_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE,
        ST_DONE: begin
          if (start) begin
            for (int n = 0; n < NK; n++)
              l_q[n] <= key_in[32*n +: 32];
            idx_q <= '0;
            run_q <= P32;
          end
        end
        ST_INIT: begin
          s_q[idx_q] <= run_q;
          run_q      <= run_q + Q32;
          if (init_last) begin
            idx_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            j_q    <= '0;
            iter_q <= '0;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        ST_MIX: begin
          s_q[idx_q] <= a_new;
          l_q[j_q]   <= b_new;
          a_q        <= a_new;
          b_q        <= b_new;
          idx_q      <= init_last ? 5'd0 : idx_q + 5'd1;
          j_q        <= j_q + 2'd1;
          iter_q     <= iter_q + 7'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    skey_rd_data = '0;
    if (skey_rd_addr < 5'(NW))
      skey_rd_data = s_q[skey_rd_addr];
  end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Scoreboard bench for rc5_key_expand against a plain RC5 key schedule.
// Stimulus pushes expected tables; a monitor checks on skey_vld rise.
module tb_rc5_key_expand;

  localparam logic [31:0] P = 32'hB7E15163;
  localparam logic [31:0] Q = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         clr;
  logic [127:0] key_in;
  logic         key_vld;
  logic         key_rdy;
  logic         skey_vld;
  logic [4:0]   skey_rd_addr;
  logic [31:0]  skey_rd_data;

  logic [4:0]   stim_addr;
  logic [4:0]   mon_addr;
  bit           mon_act;

  assign skey_rd_addr = mon_act ? mon_addr : stim_addr;

  rc5_key_expand dut (
    .clk          (clk),
    .clr          (clr),
    .key_in       (key_in),
    .key_vld      (key_vld),
    .key_rdy      (key_rdy),
    .skey_vld     (skey_vld),
    .skey_rd_addr (skey_rd_addr),
    .skey_rd_data (skey_rd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [25:0][31:0] tbl_t;
  typedef struct {
    tbl_t tbl;
    int   acc;
    bit   enc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} << (n % 32);
    return d[63:32];
  endfunction

  // Textbook RC5 key expansion
  function automatic tbl_t model(input logic [127:0] k);
    logic [31:0] S [26];
    logic [31:0] L [4];
    logic [31:0] a, b;
    int i, j;
    tbl_t r;
    a = 0; b = 0; i = 0; j = 0;
    for (int n = 0; n < 4; n++) L[n] = k[32*n +: 32];
    S[0] = P;
    for (int t = 1; t < 26; t++) S[t] = S[t-1] + Q;
    for (int n = 0; n < 78; n++) begin
      a = rl(S[i] + a + b, 3);
      S[i] = a;
      b = rl(L[j] + a + b, int'((a + b) & 32'd31));
      L[j] = b;
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
    for (int t = 0; t < 26; t++) r[t] = S[t];
    return r;
  endfunction

  initial begin
    bit seen;
    exp_t e;
    logic [31:0] w [32];
    logic [31:0] ea, eb;
    seen = 0;
    forever begin
      @(negedge clk);
      if (!skey_vld) seen = 0;
      else if (!seen) begin
        seen = 1;
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_vld actual=1 required=0");
        end else begin
          e = sbq.pop_front();
          chk("latency", 32'(cyc - e.acc), 32'd104);
          mon_act = 1;
          for (int a = 0; a < 32; a++) begin
            mon_addr = 5'(a);
            #1;
            w[a] = skey_rd_data;
            chk($sformatf("word%0d", a), w[a],
                (a < 26) ? e.tbl[a] : 32'h0);
            @(negedge clk);
          end
          mon_act = 0;
          if (e.enc) begin
            ea = w[0];
            eb = w[1];
            for (int r = 1; r <= 12; r++) begin
              ea = rl(ea ^ eb, int'(eb & 32'd31)) + w[2*r];
              eb = rl(eb ^ ea, int'(ea & 32'd31)) + w[2*r+1];
            end
            chk("enc_a", ea, 32'hEEDBA521);
            chk("enc_b", eb, 32'h6D8F4B15);
          end
          n_done++;
        end
      end
    end
  end

  task automatic issue(input logic [127:0] k, input bit push,
                       input bit enc, output int acc);
    int t;
    exp_t e;
    t = 0;
    while (!key_rdy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!key_rdy) chk("rdy_timeout", 32'(key_rdy), 32'd1);
    @(negedge clk);
    key_in  = k;
    key_vld = 1'b1;
    @(posedge clk);
    #1;
    key_vld = 1'b0;
    acc = cyc;
    chk("rdy_after_accept", 32'(key_rdy), 32'd0);
    chk("vld_after_accept", 32'(skey_vld), 32'd0);
    if (push) begin
      e.tbl = model(k);
      e.acc = acc;
      e.enc = enc;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (n_done < target && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (n_done < target) begin
      total++; bad++;
      $display("FAIL done_timeout actual=%0d required=%0d", n_done, target);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int expn;
    logic [127:0] k, k2;
    expn = 0;
    clr = 1'b0;
    key_vld = 1'b0;
    key_in = '0;
    stim_addr = '0;
    mon_addr = '0;
    mon_act = 0;

    #23;
    chk("rst_rdy", 32'(key_rdy), 32'd1);
    chk("rst_vld", 32'(skey_vld), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      stim_addr = 5'(a);
      #1;
      chk($sformatf("idle_word%0d", a), skey_rd_data, 32'h0);
    end

    issue('0, 1, 1, acc);
    expn++;
    repeat (26) @(posedge clk);
    @(negedge clk);
    stim_addr = 5'd0;
    #1 chk("init_s0", skey_rd_data, P);
    stim_addr = 5'd1;
    #1 chk("init_s1", skey_rd_data, 32'h5618CB1C);
    stim_addr = 5'd25;
    #1 chk("init_s25", skey_rd_data, P + 32'd25 * Q);
    wait_done(expn);

    for (int n = 0; n < 50; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      issue(k, 1, 0, acc);
      expn++;
      wait_done(expn);
    end

    k  = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k;
    issue(k, 1, 0, acc);
    expn++;
    repeat (9) @(negedge clk);
    chk("busy_rdy_10", 32'(key_rdy), 32'd0);
    key_in = k2;
    key_vld = 1'b1;
    @(negedge clk);
    key_vld = 1'b0;
    repeat (49) @(negedge clk);
    chk("busy_rdy_60", 32'(key_rdy), 32'd0);
    key_vld = 1'b1;
    @(negedge clk);
    key_vld = 1'b0;
    wait_done(expn);

    chk("done_vld", 32'(skey_vld), 32'd1);
    k = {$urandom, $urandom, $urandom, $urandom};
    issue(k, 1, 0, acc);
    expn++;
    wait_done(expn);

    k = {$urandom, $urandom, $urandom, $urandom};
    issue(k, 0, 0, acc);
    repeat (66) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("abort_rdy", 32'(key_rdy), 32'd1);
    chk("abort_vld", 32'(skey_vld), 32'd0);
    stim_addr = 5'd0;
    #1 chk("abort_s0", skey_rd_data, 32'h0);
    stim_addr = 5'd25;
    #1 chk("abort_s25", skey_rd_data, 32'h0);
    @(negedge clk);
    clr = 1'b1;
    repeat (120) @(negedge clk);
    chk("abort_stays_idle", 32'(skey_vld), 32'd0);

    issue('0, 1, 1, acc);
    expn++;
    wait_done(expn);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
